// File: rtl/ad_ip_jesd204_tpl_adc_pnmon_if.sv
// Link-clock bus between the deframer sample output, the PN monitor and the TPL register map.
interface ad_ip_jesd204_tpl_adc_pnmon_if #(
    parameter int W = 16
);
    logic          data_valid;
    logic [W-1:0]  data;
    logic [3:0]    pn_seq_sel;
    logic          pn_err;
    logic          pn_oos;
    logic [31:0]   pn_err_count;

    modport master (
        output data_valid, data, pn_seq_sel,
        input  pn_err, pn_oos, pn_err_count
    );

    modport slave (
        input  data_valid, data, pn_seq_sel,
        output pn_err, pn_oos, pn_err_count
    );
endinterface

// File: rtl/ad_ip_jesd204_tpl_adc_pnmon.sv
// Per-channel PN9/PN23 monitor with self-synchronising prediction from the last two beats.
// Optional saturating error counter built when PNMON_ERR_COUNTER_EN is defined.
module ad_ip_jesd204_tpl_adc_pnmon #(
    parameter int CONVERTER_RESOLUTION = 16,
    parameter int DATA_PATH_WIDTH      = 1,
    parameter int OOS_THRESHOLD        = 16
) (
    input  logic                            link_clk,
    input  logic                            link_rstn,
    ad_ip_jesd204_tpl_adc_pnmon_if.slave    pn_if
);
    localparam int         W   = CONVERTER_RESOLUTION * DATA_PATH_WIDTH;
    localparam logic [7:0] THR = 8'(OOS_THRESHOLD);

    typedef enum logic {ST_OOS, ST_SYNC} state_t;

    // Reorder the beat so the MSB is the oldest serial bit (sample 0 MSB first).
    function automatic logic [W-1:0] to_stream(input logic [W-1:0] d);
        logic [W-1:0] s;
        s = '0;
        for (int unsigned k = 0; k < DATA_PATH_WIDTH; k++)
            s[(DATA_PATH_WIDTH-1-k)*CONVERTER_RESOLUTION +: CONVERTER_RESOLUTION] =
                d[k*CONVERTER_RESOLUTION +: CONVERTER_RESOLUTION];
        return s;
    endfunction

    // Run the recurrence forward W bits past the history; newer bits sit at lower indices.
    function automatic logic [W-1:0] pn_predict(input logic [2*W-1:0] h, input logic pn23);
        logic [3*W-1:0] ext;
        int unsigned    j;
        ext = {h, {W{1'b0}}};
        for (int unsigned i = 0; i < W; i++) begin
            j = W - 1 - i;
            if (pn23)
                ext[j] = ext[j+23] ^ ext[j+18];
            else
                ext[j] = ext[j+9] ^ ext[j+5];
        end
        return ext[W-1:0];
    endfunction

    logic [3:0]     sel_q;
    logic           sel_chg;
    logic           sel_ok;
    logic [W-1:0]   data_s;
    logic [W-1:0]   exp_s;
    logic [2*W-1:0] hist;
    logic [1:0]     fill_cnt;
    logic [W-1:0]   s1_data;
    logic [W-1:0]   s1_exp;
    logic           s1_cmp;
    logic           mismatch;

    state_t         state, state_nxt;
    logic [7:0]     cnt, cnt_nxt, cnt_inc;
    logic           err_r, err_nxt;
    logic           oos_r, oos_nxt;

    assign sel_chg  = (pn_if.pn_seq_sel != sel_q);
    assign sel_ok   = (pn_if.pn_seq_sel == 4'h0) || (pn_if.pn_seq_sel == 4'h1);
    assign data_s   = to_stream(pn_if.data);
    assign exp_s    = pn_predict(hist, pn_if.pn_seq_sel[0]);
    assign mismatch = (s1_data == '0) || (s1_data != s1_exp);
    assign cnt_inc  = cnt + 8'd1;

    // Stage 1: history, data/expected registers and compare qualification.
    always_ff @(posedge link_clk or negedge link_rstn) begin
        if (!link_rstn) begin
            sel_q    <= '0;
            hist     <= '0;
            fill_cnt <= '0;
            s1_data  <= '0;
            s1_exp   <= '0;
            s1_cmp   <= 1'b0;
        end else begin
            sel_q <= pn_if.pn_seq_sel;
            if (sel_chg || !sel_ok) begin
                hist     <= '0;
                fill_cnt <= '0;
                s1_cmp   <= 1'b0;
            end else begin
                s1_cmp <= 1'b0;
                if (pn_if.data_valid) begin
                    hist    <= {hist[W-1:0], data_s};
                    s1_data <= data_s;
                    s1_exp  <= exp_s;
                    s1_cmp  <= (fill_cnt == 2'd2);
                    if (fill_cnt != 2'd2)
                        fill_cnt <= fill_cnt + 2'd1;
                end
            end
        end
    end

    // Stage 2: sync FSM and registered status.
    always_ff @(posedge link_clk or negedge link_rstn) begin
        if (!link_rstn) begin
            state <= ST_OOS;
            cnt   <= '0;
            err_r <= 1'b0;
            oos_r <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            err_r <= err_nxt;
            oos_r <= oos_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err_r;
        oos_nxt   = oos_r;
        if (sel_chg || !sel_ok) begin
            state_nxt = ST_OOS;
            cnt_nxt   = '0;
            err_nxt   = 1'b0;
            oos_nxt   = 1'b1;
        end else if (s1_cmp) begin
            unique case (state)
                ST_OOS: begin
                    err_nxt = 1'b0;
                    if (mismatch) begin
                        cnt_nxt = '0;
                    end else if (cnt_inc == THR) begin
                        state_nxt = ST_SYNC;
                        cnt_nxt   = '0;
                        oos_nxt   = 1'b0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                ST_SYNC: begin
                    if (!mismatch) begin
                        cnt_nxt = '0;
                        err_nxt = 1'b0;
                    end else if (cnt_inc == THR) begin
                        state_nxt = ST_OOS;
                        cnt_nxt   = '0;
                        err_nxt   = 1'b0;
                        oos_nxt   = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                        err_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_OOS;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign pn_if.pn_err = err_r;
    assign pn_if.pn_oos = oos_r;

`ifdef PNMON_ERR_COUNTER_EN
    logic [31:0] err_count;

    always_ff @(posedge link_clk or negedge link_rstn) begin
        if (!link_rstn)
            err_count <= '0;
        else if (sel_chg)
            err_count <= '0;
        else if (err_r && (err_count != '1))
            err_count <= err_count + 32'd1;
    end

    assign pn_if.pn_err_count = err_count;
`else
    assign pn_if.pn_err_count = '0;
`endif

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pnmon.sv
// Directed bench for the PN monitor: lock, bit error, idle link, sequence switch, gaps, off mode, reset.
module tb_ad_ip_jesd204_tpl_adc_pnmon;
    logic link_clk  = 1'b0;
    logic link_rstn = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [63:0] sh;
    logic        use_pn23;
    logic [15:0] d;

    ad_ip_jesd204_tpl_adc_pnmon_if #(.W(16)) pn_if ();

    ad_ip_jesd204_tpl_adc_pnmon #(
        .CONVERTER_RESOLUTION (16),
        .DATA_PATH_WIDTH      (1),
        .OOS_THRESHOLD        (16)
    ) dut (
        .link_clk  (link_clk),
        .link_rstn (link_rstn),
        .pn_if     (pn_if)
    );

    always #5 link_clk = ~link_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serial reference: sh[0] is the newest bit, beat is built MSB (oldest) first.
    task automatic next_pn(output logic [15:0] beat_d);
        logic b;
        for (int i = 15; i >= 0; i--) begin
            b = use_pn23 ? (sh[22] ^ sh[17]) : (sh[8] ^ sh[4]);
            sh = {sh[62:0], b};
            beat_d[i] = b;
        end
    endtask

    task automatic beat(input logic v, input logic [15:0] bd);
        pn_if.data_valid = v;
        pn_if.data       = bd;
        @(posedge link_clk);
        #1;
    endtask

    task automatic pn_beat();
        logic [15:0] bd;
        next_pn(bd);
        beat(1'b1, bd);
    endtask

    initial begin
        pn_if.data_valid = 1'b0;
        pn_if.data       = '0;
        pn_if.pn_seq_sel = 4'h0;
        use_pn23         = 1'b0;
        sh               = 64'h0000_0000_0055_AA33;

        repeat (3) @(posedge link_clk);
        #1;
        chk("rst_oos", 32'(pn_if.pn_oos), 32'd1);
        chk("rst_err", 32'(pn_if.pn_err), 32'd0);
        chk("rst_cnt", pn_if.pn_err_count, 32'd0);
        link_rstn = 1'b1;
        beat(1'b0, 16'h0);

        // PN9 lock: 2 fill beats + 16 matches, visible one cycle after the 18th beat is captured
        for (int i = 1; i <= 18; i++) begin
            pn_beat();
            chk("lock9_err", 32'(pn_if.pn_err), 32'd0);
        end
        chk("lock9_pre", 32'(pn_if.pn_oos), 32'd1);
        beat(1'b0, 16'hDEAD);
        chk("lock9_oos", 32'(pn_if.pn_oos), 32'd0);
        repeat (3) beat(1'b0, 16'h1234);
        chk("hold_oos", 32'(pn_if.pn_oos), 32'd0);
        repeat (3) pn_beat();
        chk("clean_err", 32'(pn_if.pn_err), 32'd0);

        // Single bit error
        next_pn(d);
        beat(1'b1, d ^ 16'h0100);
        chk("flip_pre", 32'(pn_if.pn_err), 32'd0);
        pn_beat();
        chk("flip_err", 32'(pn_if.pn_err), 32'd1);
        chk("flip_oos", 32'(pn_if.pn_oos), 32'd0);
        for (int i = 0; i < 4; i++) begin
            pn_beat();
            chk("flip_oos_hold", 32'(pn_if.pn_oos), 32'd0);
        end
        chk("flip_clear", 32'(pn_if.pn_err), 32'd0);
`ifdef PNMON_ERR_COUNTER_EN
        chk("flip_count", pn_if.pn_err_count, 32'd2);
`else
        chk("flip_count", pn_if.pn_err_count, 32'd0);
`endif

        // Idle link: 16 all-zero beats drop sync
        for (int i = 1; i <= 16; i++) begin
            beat(1'b1, 16'h0000);
            if (i >= 2) chk("zero_err", 32'(pn_if.pn_err), 32'd1);
            chk("zero_oos", 32'(pn_if.pn_oos), 32'd0);
        end
        beat(1'b0, 16'h0);
        chk("zero_oos_end", 32'(pn_if.pn_oos), 32'd1);
        chk("zero_err_end", 32'(pn_if.pn_err), 32'd0);
`ifdef PNMON_ERR_COUNTER_EN
        chk("zero_count", pn_if.pn_err_count, 32'd17);
`endif

        // Relock PN9 then switch to PN23 with gapped valid
        repeat (20) pn_beat();
        beat(1'b0, 16'h0);
        chk("relock9_oos", 32'(pn_if.pn_oos), 32'd0);
        pn_if.pn_seq_sel = 4'h1;
        use_pn23 = 1'b1;
        sh = 64'h0000_0000_005A_5C3B;
        beat(1'b0, 16'h0);
        chk("sw_oos", 32'(pn_if.pn_oos), 32'd1);
        chk("sw_err", 32'(pn_if.pn_err), 32'd0);
        chk("sw_count", pn_if.pn_err_count, 32'd0);
        for (int i = 1; i <= 18; i++) begin
            pn_beat();
            if (i == 18) chk("lock23_pre", 32'(pn_if.pn_oos), 32'd1);
            beat(1'b0, 16'($urandom));
            chk("lock23_err", 32'(pn_if.pn_err), 32'd0);
        end
        chk("lock23_oos", 32'(pn_if.pn_oos), 32'd0);

        // Unsupported selection: monitor off
        pn_if.pn_seq_sel = 4'h7;
        for (int i = 0; i < 20; i++) begin
            beat(1'b1, 16'($urandom));
            chk("off_oos", 32'(pn_if.pn_oos), 32'd1);
            chk("off_err", 32'(pn_if.pn_err), 32'd0);
        end
        chk("off_count", pn_if.pn_err_count, 32'd0);

        // Back to PN9, lock, then asynchronous reset mid-cycle
        pn_if.pn_seq_sel = 4'h0;
        use_pn23 = 1'b0;
        sh = 64'h0000_0000_0000_01A7;
        beat(1'b0, 16'h0);
        repeat (20) pn_beat();
        beat(1'b0, 16'h0);
        chk("relock_oos", 32'(pn_if.pn_oos), 32'd0);
        #2;
        link_rstn = 1'b0;
        #1;
        chk("async_rst_oos", 32'(pn_if.pn_oos), 32'd1);
        chk("async_rst_err", 32'(pn_if.pn_err), 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
